// File: rtl/dpram_pkg.sv
// dpram_pkg: shared types and helpers for the byte-enabled dual-port RAM.
//   state_e     : clear sequencer states (CLEAR, READY)
//   BYTE_W      : width of one write lane
//   log2c()     : ceiling log2, usable in localparam expressions
//   byte_merge(): one lane of a strobed merge (new byte when strb, else old)
package dpram_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  function automatic int log2c(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic logic [BYTE_W-1:0] byte_merge(input logic [BYTE_W-1:0] old_b,
                                                   input logic [BYTE_W-1:0] new_b,
                                                   input logic              strb);
    return strb ? new_b : old_b;
  endfunction

endpackage

// File: rtl/dpram_be_if.sv
// dpram_be_if: bus bundle between a requester (master) and the RAM (slave).
//   Read : rd_req/addr_r in; rdata/rd_valid/rd_err out (rd_err qualifies rd_valid).
//   Write: we/addr_w/wdata/wstrb in; wr_err out (pulse after a rejected write).
//   Status: init_busy (clear sequence running), dbg_state (sequencer state).
// Handshake: a request is accepted on every rising edge where rd_req=1 while
// init_busy=0; the response appears as a single-cycle rd_valid pulse on the
// next cycle. There is no ready/backpressure: the RAM accepts one read and one
// write per cycle unconditionally once initialised.
interface dpram_be_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  import dpram_pkg::*;

  logic                  rd_req;
  logic [ADDR_W-1:0]     addr_r;
  logic [DATA_W-1:0]     rdata;
  logic                  rd_valid;
  logic                  rd_err;
  logic                  we;
  logic [ADDR_W-1:0]     addr_w;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  wr_err;
  logic                  init_busy;
  state_e                dbg_state;

  modport master (
    output rd_req, addr_r, we, addr_w, wdata, wstrb,
    input  rdata, rd_valid, rd_err, wr_err, init_busy, dbg_state
  );

  modport slave (
    input  rd_req, addr_r, we, addr_w, wdata, wstrb,
    output rdata, rd_valid, rd_err, wr_err, init_busy, dbg_state
  );

endinterface

// File: rtl/dpram_clear_seq.sv
// dpram_clear_seq: after reset, walks every word index once and requests an
// all-zero write to it, then parks in READY until the next reset.
//   m_clock, p_reset : clock, async active-low reset
//   clr_we           : clear write request for word clr_idx this cycle
//   clr_idx          : word index being cleared
//   init_busy        : high while in CLEAR
//   state            : current state, for observation
module dpram_clear_seq
  import dpram_pkg::*;
#(
  parameter int WORDS      = 1024,
  parameter int IDX_W      = 10,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic             m_clock,
  input  logic             p_reset,
  output logic             clr_we,
  output logic [IDX_W-1:0] clr_idx,
  output logic             init_busy,
  output state_e           state
);

  localparam state_e RESET_STATE = INIT_CLEAR ? CLEAR : READY;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state_q <= RESET_STATE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    clr_we    = 1'b0;
    init_busy = 1'b0;
    unique case (state_q)
      CLEAR: begin
        clr_we    = 1'b1;
        init_busy = 1'b1;
        // Last word is written on the same edge that enters READY.
        if (ptr_q == IDX_W'(WORDS - 1)) begin
          state_d = READY;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      READY: begin
      end
      default: begin
      end
    endcase
  end

  assign clr_idx = ptr_q;
  assign state   = state_q;

endmodule

// File: rtl/dpram_be.sv
// dpram_be: byte-addressed RAM with one strobed write port and one registered
// read port (latency 1, one request per cycle), write-first on same-word
// collisions, and a hardware zeroing pass after reset.
//   m_clock, p_reset : clock, async active-low reset
//   bus (slave)      : read/write request bus, error pulses, init_busy, dbg_state
// Only aligned, in-range addresses touch the array; upper address bits are
// not aliased, so anything at or above DEPTH_BYTES is an error.
module dpram_be
  import dpram_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 4096,
  parameter bit INIT_CLEAR  = 1'b1
) (
  input  logic     m_clock,
  input  logic     p_reset,
  dpram_be_if.slave bus
);

  localparam int BYTES = DATA_W / BYTE_W;
  localparam int WORDS = DEPTH_BYTES / BYTES;
  localparam int OFF_W = log2c(BYTES);
  localparam int IDX_W = (log2c(WORDS) > 0) ? log2c(WORDS) : 1;

  logic [DATA_W-1:0] mem [WORDS];

  logic             clr_we;
  logic [IDX_W-1:0] clr_idx;
  logic             init_busy;
  state_e           state;

  dpram_clear_seq #(
    .WORDS      (WORDS),
    .IDX_W      (IDX_W),
    .INIT_CLEAR (INIT_CLEAR)
  ) u_clear_seq (
    .m_clock   (m_clock),
    .p_reset   (p_reset),
    .clr_we    (clr_we),
    .clr_idx   (clr_idx),
    .init_busy (init_busy),
    .state     (state)
  );

  assign bus.init_busy = init_busy;
  assign bus.dbg_state = state;

  // Address decode for both ports.
  logic             r_good, w_good;
  logic [IDX_W-1:0] r_idx, w_idx;

  assign r_good = ((bus.addr_r & ADDR_W'(BYTES - 1)) == '0) && (bus.addr_r < ADDR_W'(DEPTH_BYTES));
  assign w_good = ((bus.addr_w & ADDR_W'(BYTES - 1)) == '0) && (bus.addr_w < ADDR_W'(DEPTH_BYTES));
  assign r_idx  = bus.addr_r[OFF_W +: IDX_W];
  assign w_idx  = bus.addr_w[OFF_W +: IDX_W];

  logic ready;
  logic rd_fire;
  logic user_wr;
  logic collide;

  assign ready   = !init_busy;
  assign rd_fire = ready && bus.rd_req;
  assign user_wr = ready && bus.we && w_good;
  assign collide = user_wr && r_good && (r_idx == w_idx);

  // Array write: clear sequencer has priority and owns the port while busy.
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [BYTES-1:0]  lane_we;

  always_comb begin
    wr_idx  = w_idx;
    wr_data = bus.wdata;
    lane_we = user_wr ? bus.wstrb : '0;
    if (clr_we) begin
      wr_idx  = clr_idx;
      wr_data = '0;
      lane_we = '1;
    end
  end

  always_ff @(posedge m_clock) begin
    for (int k = 0; k < BYTES; k++) begin
      if (lane_we[k]) mem[wr_idx][k*BYTE_W +: BYTE_W] <= wr_data[k*BYTE_W +: BYTE_W];
    end
  end

  // Read data with write-first forwarding of strobed lanes on collision.
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < BYTES; k++) begin
      rd_word[k*BYTE_W +: BYTE_W] = byte_merge(mem[r_idx][k*BYTE_W +: BYTE_W],
                                               bus.wdata[k*BYTE_W +: BYTE_W],
                                               bus.wstrb[k] && collide);
    end
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      bus.rdata    <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_err   <= 1'b0;
      bus.wr_err   <= 1'b0;
    end else begin
      bus.rd_valid <= rd_fire;
      bus.rd_err   <= rd_fire && !r_good;
      bus.wr_err   <= ready && bus.we && !w_good;
      // rdata is only updated by a response, so it holds between pulses.
      if (rd_fire) bus.rdata <= r_good ? rd_word : '0;
    end
  end

endmodule

// File: tb/tb_dpram_be.sv
// tb_dpram_be: randomized and directed checks of dpram_be against a
// word-array reference model of the RAM.
module tb_dpram_be;

  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 32;
  localparam int DEPTH_BYTES = 4096;
  localparam int WORDS       = DEPTH_BYTES / 4;

  // ---------------- clock / reset ----------------
  logic m_clock;
  logic p_reset;

  initial m_clock = 1'b0;
  always #5 m_clock = ~m_clock;

  dpram_be_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dpram_be #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .DEPTH_BYTES (DEPTH_BYTES),
    .INIT_CLEAR  (1'b1)
  ) u_dut (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .bus     (bus.slave)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ref_mem [WORDS];
  logic [32:0] exp_q [$];        // {rd_err, rdata}
  logic [31:0] last_rdata;
  bit          model_ready;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    return (a % 4 == 0) && (a < DEPTH_BYTES);
  endfunction

  // Returns 1 when the write is accepted.
  function automatic bit model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    if (!addr_ok(a)) return 1'b0;
    w = ref_mem[a / 4];
    for (int k = 0; k < 4; k++)
      if (s[k]) w[8*k +: 8] = d[8*k +: 8];
    ref_mem[a / 4] = w;
    return 1'b1;
  endfunction

  function automatic logic [32:0] model_read(input logic [31:0] a);
    if (!addr_ok(a)) return {1'b1, 32'h0};
    return {1'b0, ref_mem[a / 4]};
  endfunction

  // ---------------- driver ----------------
  // One clock cycle: present inputs, update model (write before read gives
  // write-first), step the edge, then compare outputs.
  task automatic cycle(input logic rd, input logic [31:0] ar, input logic w,
                       input logic [31:0] aw, input logic [31:0] wd, input logic [3:0] ws);
    logic        exp_werr;
    logic        exp_valid;
    logic [32:0] e;
    bus.rd_req = rd;
    bus.addr_r = ar;
    bus.we     = w;
    bus.addr_w = aw;
    bus.wdata  = wd;
    bus.wstrb  = ws;
    exp_werr  = 1'b0;
    exp_valid = 1'b0;
    if (model_ready) begin
      if (w) exp_werr = !model_write(aw, wd, ws);
      if (rd) begin
        exp_q.push_back(model_read(ar));
        exp_valid = 1'b1;
      end
    end
    @(posedge m_clock);
    #1;
    check("rd_valid", 64'(bus.rd_valid), 64'(exp_valid));
    check("wr_err", 64'(bus.wr_err), 64'(exp_werr));
    if (exp_valid) begin
      e = exp_q.pop_front();
      check("rdata", 64'(bus.rdata), 64'(e[31:0]));
      check("rd_err", 64'(bus.rd_err), 64'(e[32]));
      last_rdata = e[31:0];
    end else begin
      check("rdata_hold", 64'(bus.rdata), 64'(last_rdata));
      check("rd_err_idle", 64'(bus.rd_err), 64'h0);
    end
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic do_reset();
    model_ready = 1'b0;
    exp_q.delete();
    bus.rd_req = 1'b0;
    bus.we     = 1'b0;
    p_reset    = 1'b0;
    #1;
    check("rst_rdata", 64'(bus.rdata), 64'h0);
    check("rst_rd_valid", 64'(bus.rd_valid), 64'h0);
    check("rst_rd_err", 64'(bus.rd_err), 64'h0);
    check("rst_wr_err", 64'(bus.wr_err), 64'h0);
    check("rst_init_busy", 64'(bus.init_busy), 64'h1);
    @(posedge m_clock);
    #1;
    p_reset    = 1'b1;
    last_rdata = 32'h0;
  endtask

  // Counts cycles until init_busy drops; optionally pokes both ports early on.
  task automatic wait_clear(input bit poke);
    int cnt;
    cnt = 0;
    model_ready = 1'b0;
    while (bus.init_busy && cnt < 2000) begin
      if (poke && cnt < 10) cycle(1'b1, 32'h40, 1'b1, 32'h40, $urandom, 4'hF);
      else idle();
      cnt++;
    end
    check("init_busy_cycles", 64'(cnt), 64'd1024);
    for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'h0;
    model_ready = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    p_reset     = 1'b1;
    model_ready = 1'b0;
    last_rdata  = 32'h0;
    bus.rd_req  = 1'b0;
    bus.addr_r  = '0;
    bus.we      = 1'b0;
    bus.addr_w  = '0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    #2;

    // Reset, clear length, port activity during clear is ignored.
    do_reset();
    wait_clear(1'b1);
    cycle(1'b1, 32'h000, 1'b0, 0, 0, 0);
    check("t1_rd0", 64'(bus.rdata), 64'h0);
    cycle(1'b1, 32'hFFC, 1'b0, 0, 0, 0);
    check("t1_rdFFC", 64'(bus.rdata), 64'h0);
    cycle(1'b1, 32'h040, 1'b0, 0, 0, 0);
    check("t5_word40", 64'(bus.rdata), 64'h0);

    // Strobed partial write.
    cycle(1'b0, 0, 1'b1, 32'h010, 32'hDEADBEEF, 4'hF);
    cycle(1'b0, 0, 1'b1, 32'h010, 32'h11223344, 4'h5);
    cycle(1'b1, 32'h010, 1'b0, 0, 0, 0);
    check("t2_merge", 64'(bus.rdata), 64'hDE22BE44);

    // Write-first collision, then a later write not affecting an issued read.
    cycle(1'b0, 0, 1'b1, 32'h020, 32'hAAAAAAAA, 4'hF);
    cycle(1'b1, 32'h020, 1'b1, 32'h020, 32'h55555555, 4'h3);
    check("t3_collide", 64'(bus.rdata), 64'hAAAA5555);
    cycle(1'b1, 32'h020, 1'b0, 0, 0, 0);
    cycle(1'b0, 0, 1'b1, 32'h020, 32'h12345678, 4'hF);
    check("t3_after", 64'(bus.rdata), 64'hAAAA5555);
    cycle(1'b1, 32'h020, 1'b0, 0, 0, 4'h0);
    check("t3_new", 64'(bus.rdata), 64'h12345678);

    // Bad addresses; wstrb=0 no-op.
    cycle(1'b0, 0, 1'b1, 32'h011, 32'hFFFFFFFF, 4'hF);
    check("t4_misalign_err", 64'(bus.wr_err), 64'h1);
    cycle(1'b0, 0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF);
    check("t4_range_err", 64'(bus.wr_err), 64'h1);
    cycle(1'b0, 0, 1'b1, 32'h010, 32'hFFFFFFFF, 4'h0);
    cycle(1'b1, 32'h1000, 1'b0, 0, 0, 0);
    check("t4_rd_err", 64'(bus.rd_err), 64'h1);
    cycle(1'b1, 32'h010, 1'b0, 0, 0, 0);
    check("t4_unchanged", 64'(bus.rdata), 64'hDE22BE44);
    idle();

    // Random traffic over a small window to force collisions.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ar, aw;
      ar = 32'($urandom_range(0, 15)) * 4;
      aw = 32'($urandom_range(0, 15)) * 4;
      if ($urandom_range(0, 15) == 0) ar = ar + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) aw = aw + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 31) == 0) ar = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
      if ($urandom_range(0, 31) == 0) aw = 32'hFFC + 32'($urandom_range(1, 64)) * 4;
      cycle(1'($urandom_range(0, 1)), ar, 1'($urandom_range(0, 1)), aw,
            $urandom, 4'($urandom_range(0, 15)));
    end
    idle();

    // Reset in the middle of the clear pass restarts it.
    do_reset();
    for (int i = 0; i < 500; i++) idle();
    check("t6_busy_mid", 64'(bus.init_busy), 64'h1);
    do_reset();
    wait_clear(1'b0);

    // Back-to-back reads in address order.
    for (int i = 0; i < 8; i++) cycle(1'b0, 0, 1'b1, 32'(i * 4), 32'h10000000 + 32'(i), 4'hF);
    for (int i = 0; i < 8; i++) begin
      a = 32'(i * 4);
      cycle(1'b1, a, 1'b0, 0, 0, 0);
      check("t6_b2b_valid", 64'(bus.rd_valid), 64'h1);
      check("t6_b2b_data", 64'(bus.rdata), 64'h10000000 + 64'(i));
    end
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
